kypd_scan_ctrl: RTL and testbench

- Sequences the 4x4 Pmod keypad: drives the columns one at a time, samples the rows, and debounces whole scan frames.
- Emits one single-cycle key event per press, with the hex key code.
- Replaces free-running decoder-plus-per-bit debounce; feeds digit-entry and display-select logic for the two-digit SSD.
- Sits between the kypd inout pins (col = kypd[7:4], row = kypd[3:0]) and the display controller.

---
 rtl/kypd_pkg.sv | 16 +
 rtl/kypd_col_scanner.sv | 36 +++
 rtl/kypd_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_kypd_scan_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/kypd_pkg.sv
// kypd_pkg: shared types, keypad geometry and key map for the Pmod keypad scanner.
// Auto-repeat in kypd_scan_ctrl is enabled with KYPD_REPEAT_EN.
package kypd_pkg;
    typedef enum logic [1:0] {IDLE, CAND, PRESSED} state_t;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam logic [3:0] KEYMAP [0:NUM_ROWS-1][0:NUM_COLS-1] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };
    function automatic logic [3:0] key_lookup(input logic [1:0] row_idx, input logic [1:0] col_idx);
        return KEYMAP[row_idx][col_idx];
    endfunction
endpackage

// File: rtl/kypd_col_scanner.sv
// kypd_col_scanner: free-running column drive with settle time, row synchronizer,
// per-column sample strobe and frame-end strobe.
module kypd_col_scanner #(
    parameter int SETTLE_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_row,
    output logic [3:0] o_col,
    output logic [3:0] o_row,
    output logic       o_sample,
    output logic       o_frame_end
);
    localparam int SW = $clog2(SETTLE_CYC) + 1;
    localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYC - 1);
    logic [3:0]    r_sync1, r_sync2;
    logic [SW-1:0] r_settle;
    logic [1:0]    r_idx;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 4'hF;
            r_sync2  <= 4'hF;
            r_settle <= '0;
            r_idx    <= '0;
        end else begin
            r_sync1  <= i_row;
            r_sync2  <= r_sync1;
            r_settle <= o_sample ? '0 : r_settle + 1'b1;
            r_idx    <= r_idx + {1'b0, o_sample};
        end
    end
    assign o_sample    = r_settle == S_LAST;
    assign o_frame_end = o_sample && r_idx == 2'd3;
    assign o_col       = ~(4'b0001 << r_idx);
    assign o_row       = r_sync2;
endmodule

// File: rtl/kypd_scan_ctrl.sv
// kypd_scan_ctrl: 4x4 keypad scan, whole-frame debounce and single-cycle key events.
// Define KYPD_REPEAT_EN to emit auto-repeat events while a key stays held.
module kypd_scan_ctrl
    import kypd_pkg::*;
#(
    parameter int SETTLE_CYC     = 1000,
    parameter int DEBOUNCE_SCANS = 8,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_key
);
    localparam int CW = $clog2(DEBOUNCE_SCANS) + 1;
    localparam logic [CW-1:0] DEB_M1 = CW'(DEBOUNCE_SCANS - 1);
    logic          w_sample, w_frame_end, w_rep_fire, w_valid_nxt;
    logic [3:0]    w_row_s, w_code, w_cand_nxt, w_code_nxt, r_cand, r_key_code;
    logic [11:0]   r_keys;
    logic [15:0]   w_frame;
    logic [1:0]    w_n;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_key_valid, r_multi;
    state_t        r_state, w_state_nxt;
    kypd_col_scanner #(.SETTLE_CYC(SETTLE_CYC)) u_scan (
        .clk(clk), .rst(rst), .i_row(row), .o_col(col), .o_row(w_row_s),
        .o_sample(w_sample), .o_frame_end(w_frame_end)
    );
    // Columns 0..2 are shifted in as they are sampled; column 3 joins live at frame end.
    assign w_frame = {~w_row_s, r_keys};
    always_comb begin
        w_n    = '0;
        w_code = '0;
        for (int c = 0; c < NUM_COLS; c++)
            for (int r = 0; r < NUM_ROWS; r++)
                if (w_frame[c*NUM_ROWS + r]) begin
                    w_n    = (w_n == 2'd2) ? 2'd2 : w_n + 2'd1;
                    w_code = key_lookup(2'(r), 2'(c));
                end
    end
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_key_code;
        w_valid_nxt = 1'b0;
        if (w_frame_end)
            case (r_state)
                IDLE: if (w_n == 2'd1) begin
                    w_state_nxt = CAND;
                    w_cand_nxt  = w_code;
                    w_cnt_nxt   = CW'(1);
                end
                CAND: if (w_n == 2'd1 && w_code == r_cand) begin
                    w_cnt_nxt = (r_cnt == DEB_M1) ? '0 : r_cnt + 1'b1;
                    if (r_cnt == DEB_M1) begin
                        w_state_nxt = PRESSED;
                        w_code_nxt  = r_cand;
                        w_valid_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
                PRESSED: begin
                    w_valid_nxt = w_rep_fire;
                    w_cnt_nxt   = (w_n != 2'd0 || r_cnt == DEB_M1) ? '0 : r_cnt + 1'b1;
                    w_state_nxt = (w_n == 2'd0 && r_cnt == DEB_M1) ? IDLE : PRESSED;
                end
                default: w_state_nxt = IDLE;
            endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cand      <= '0;
            r_cnt       <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_multi     <= 1'b0;
            r_keys      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cand      <= w_cand_nxt;
            r_cnt       <= w_cnt_nxt;
            r_key_code  <= w_code_nxt;
            r_key_valid <= w_valid_nxt;
            if (w_sample) r_keys <= {~w_row_s, r_keys[11:4]};
            if (w_frame_end) r_multi <= w_n == 2'd2;
        end
    end
`ifdef KYPD_REPEAT_EN
    localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW = $clog2(HMAX) + 1;
    localparam logic [HW-1:0] DELAY_M1 = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] RATE_M1  = HW'(REPEAT_RATE - 1);
    logic [HW-1:0] r_hold;
    logic          r_rep, w_match;
    assign w_match    = r_state == PRESSED && w_n == 2'd1 && w_code == r_key_code;
    assign w_rep_fire = w_match && r_hold == (r_rep ? RATE_M1 : DELAY_M1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
            r_rep  <= 1'b0;
        end else if (w_frame_end) begin
            r_hold <= (!w_match || w_rep_fire) ? '0 : r_hold + 1'b1;
            r_rep  <= w_match && (r_rep || w_rep_fire);
        end
    end
`else
    // Repeat timing has no effect when auto-repeat is compiled out.
    assign w_rep_fire = 1'b0 & (REPEAT_DELAY > REPEAT_RATE);
`endif
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_state == PRESSED;
    assign multi_key = r_multi;
endmodule

// File: tb/tb_kypd_scan_ctrl.sv
// tb_kypd_scan_ctrl: directed keypad scenarios with an event scoreboard
// (SETTLE_CYC=4, DEBOUNCE_SCANS=3, 16-cycle frames; honours KYPD_REPEAT_EN).
module tb_kypd_scan_ctrl;
    logic        clk, rst;
    logic [3:0]  row, col, key_code;
    logic        key_valid, key_held, multi_key;
    logic [15:0] keys;
    logic [3:0]  exp_q [$];
    logic [3:0]  e_col;
    int          n_assert = 0, n_fail = 0;
    localparam int FR = 16;
    localparam logic [15:0] K1 = 16'h0001, K5 = 16'h0020, K9 = 16'h0400, KA = 16'h1000, KD = 16'h8000;

    kypd_scan_ctrl #(.SETTLE_CYC(4), .DEBOUNCE_SCANS(3), .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code),
        .key_valid(key_valid), .key_held(key_held), .multi_key(multi_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c*4 + r] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (key_valid) begin
                if (exp_q.size() > 0) check("event_code", key_code, exp_q.pop_front());
                else check("unexpected_valid", key_valid, 1'b0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        keys = '0;
        step(3);
        check("rst_col", col, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held", key_held, 1'b0);
        check("rst_multi", multi_key, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 2*FR; k++) begin
            e_col = ~(4'b0001 << ((k/4) % 4));
            check("col_seq", col, e_col);
            step(1);
        end
        check("idle_held", key_held, 1'b0);
        check("idle_multi", multi_key, 1'b0);

        keys = K5;
        step(2*FR);
        check("k5_not_yet_held", key_held, 1'b0);
        exp_q.push_back(4'h5);
        step(FR);
        check("k5_held", key_held, 1'b1);
        check("k5_code", key_code, 4'h5);
        step(2*FR);
        check("k5_still_held", key_held, 1'b1);
        keys = '0;
        step(2*FR);
        check("k5_release_2", key_held, 1'b1);
        step(FR);
        check("k5_released", key_held, 1'b0);
        check("k5_queue", 16'(exp_q.size()), 16'd0);

        keys = K5;
        step(2*FR);
        keys = '0;
        step(FR);
        keys = K5;
        step(2*FR);
        check("gap_no_event", key_held, 1'b0);
        exp_q.push_back(4'h5);
        step(FR);
        check("gap_held", key_held, 1'b1);
        keys = '0;
        step(3*FR);
        check("gap_released", key_held, 1'b0);

        keys = K1 | K9;
        step(FR);
        check("multi_1", multi_key, 1'b1);
        step(FR);
        check("multi_2", multi_key, 1'b1);
        check("multi_no_held", key_held, 1'b0);
        keys = K9;
        step(FR);
        check("multi_cleared", multi_key, 1'b0);
        step(FR);
        exp_q.push_back(4'h9);
        step(FR);
        check("k9_code", key_code, 4'h9);
        check("k9_held", key_held, 1'b1);
        keys = '0;
        step(3*FR);
        check("k9_released", key_held, 1'b0);

        keys = KD;
        step(FR + 8);
        rst = 1'b1;
        #1;
        check("mid_rst_col", col, 4'b1110);
        check("mid_rst_code", key_code, 4'h0);
        check("mid_rst_valid", key_valid, 1'b0);
        check("mid_rst_held", key_held, 1'b0);
        check("mid_rst_multi", multi_key, 1'b0);
        step(2);
        rst = 1'b0;
        step(2*FR);
        check("kd_not_yet", key_held, 1'b0);
        exp_q.push_back(4'hD);
        step(FR);
        check("kd_held", key_held, 1'b1);
        keys = '0;
        step(3*FR);
        check("kd_released", key_held, 1'b0);

        keys = KA;
        step(2*FR);
        exp_q.push_back(4'hA);
        step(FR);
        check("ka_code", key_code, 4'hA);
`ifdef KYPD_REPEAT_EN
        step(3*FR);
        exp_q.push_back(4'hA);
        step(2*FR);
        exp_q.push_back(4'hA);
        step(2*FR);
        exp_q.push_back(4'hA);
        step(2*FR);
`else
        step(9*FR);
`endif
        check("ka_queue", 16'(exp_q.size()), 16'd0);
        check("ka_held", key_held, 1'b1);
        keys = '0;
        step(3*FR);
        check("ka_released", key_held, 1'b0);
        check("final_queue", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
